// File: rtl/drone_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | drone_pkg: state width and state codes shared by the drone control FSM  |
// | and any db_estado decoder.                     Revision: 1.0            |
// +-------------------------------------------------------------------------+
package drone_pkg;

    localparam int LARGURA_ESTADO = 4;

    localparam logic [LARGURA_ESTADO-1:0] COD_INICIAL       = 4'd0;
    localparam logic [LARGURA_ESTADO-1:0] COD_PREPARA       = 4'd1;
    localparam logic [LARGURA_ESTADO-1:0] COD_ESCOLHE_MODO  = 4'd2;
    localparam logic [LARGURA_ESTADO-1:0] COD_ESCOLHE_VIDA  = 4'd3;
    localparam logic [LARGURA_ESTADO-1:0] COD_INICIA_JOGADA = 4'd4;
    localparam logic [LARGURA_ESTADO-1:0] COD_ESPERA        = 4'd5;
    localparam logic [LARGURA_ESTADO-1:0] COD_COMPARA       = 4'd6;
    localparam logic [LARGURA_ESTADO-1:0] COD_DESLOCA       = 4'd7;
    localparam logic [LARGURA_ESTADO-1:0] COD_GANHOU        = 4'd8;
    localparam logic [LARGURA_ESTADO-1:0] COD_PERDEU        = 4'd9;

    typedef enum logic [LARGURA_ESTADO-1:0] {
        INICIAL       = COD_INICIAL,
        PREPARA       = COD_PREPARA,
        ESCOLHE_MODO  = COD_ESCOLHE_MODO,
        ESCOLHE_VIDA  = COD_ESCOLHE_VIDA,
        INICIA_JOGADA = COD_INICIA_JOGADA,
        ESPERA        = COD_ESPERA,
        COMPARA       = COD_COMPARA,
        DESLOCA       = COD_DESLOCA,
        GANHOU        = COD_GANHOU,
        PERDEU        = COD_PERDEU
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/edge_detector.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | edge_detector: one-cycle pulse on each rising edge of sinal.            |
// |                                                Revision: 1.0            |
// +-------------------------------------------------------------------------+
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic sinal_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinal_q <= 1'b0;
        end else begin
            sinal_q <= sinal;
        end
    end

    assign pulso = sinal & ~sinal_q;

endmodule
`default_nettype wire

// File: rtl/unidade_controle_drone.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | unidade_controle_drone: Moore FSM sequencing one drone game round.      |
// |                                                Revision: 1.0            |
// +-------------------------------------------------------------------------+
module unidade_controle_drone
    import drone_pkg::*;
#(
    parameter int LARGURA_ESTADO = drone_pkg::LARGURA_ESTADO
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      iniciar,
    input  logic                      confirma,
    input  logic                      colisao,
    input  logic                      fim_espera,
    input  logic                      fim_mapa,
    output logic                      zeraPosicoes,
    output logic                      resetaVidas,
    output logic                      zeraT,
    output logic                      contaT,
    output logic                      move_drone,
    output logic                      desloca_horizontal,
    output logic                      escolhe_modo,
    output logic                      escolhe_vida,
    output logic                      pronto,
    output logic                      ganhou,
    output logic                      perdeu,
    output logic [LARGURA_ESTADO-1:0] db_estado
);

    estado_t estado;
    estado_t proximo;
    logic    conf_p;

    edge_detector u_conf_edge (
        .clock (clock),
        .reset (reset),
        .sinal (confirma),
        .pulso (conf_p)
    );

    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:       if (iniciar) proximo = PREPARA;
            PREPARA:       proximo = ESCOLHE_MODO;
            ESCOLHE_MODO:  if (conf_p) proximo = ESCOLHE_VIDA;
            ESCOLHE_VIDA:  if (conf_p) proximo = INICIA_JOGADA;
            INICIA_JOGADA: proximo = ESPERA;
            ESPERA:        if (fim_espera) proximo = COMPARA;
            // Collision outranks reaching the end of the map.
            COMPARA:       if (colisao)       proximo = PERDEU;
                           else if (fim_mapa) proximo = GANHOU;
                           else               proximo = DESLOCA;
            DESLOCA:       proximo = ESPERA;
            GANHOU,
            PERDEU:        if (iniciar)     proximo = PREPARA;
                           else if (conf_p) proximo = ESCOLHE_MODO;
            default:       proximo = INICIAL;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado             <= INICIAL;
            zeraPosicoes       <= 1'b0;
            resetaVidas        <= 1'b0;
            zeraT              <= 1'b0;
            contaT             <= 1'b0;
            move_drone         <= 1'b0;
            desloca_horizontal <= 1'b0;
            escolhe_modo       <= 1'b0;
            escolhe_vida       <= 1'b0;
            pronto             <= 1'b0;
            ganhou             <= 1'b0;
            perdeu             <= 1'b0;
        end else begin
            estado             <= proximo;
            zeraPosicoes       <= (proximo == PREPARA) || (proximo == INICIA_JOGADA);
            resetaVidas        <= (proximo == PREPARA);
            zeraT              <= (proximo == PREPARA) || (proximo == INICIA_JOGADA)
                                  || (proximo == DESLOCA);
            contaT             <= (proximo == ESPERA);
            move_drone         <= (proximo == ESPERA);
            desloca_horizontal <= (proximo == DESLOCA);
            escolhe_modo       <= (proximo == ESCOLHE_MODO);
            escolhe_vida       <= (proximo == ESCOLHE_VIDA);
            pronto             <= (proximo == GANHOU) || (proximo == PERDEU);
            ganhou             <= (proximo == GANHOU);
            perdeu             <= (proximo == PERDEU);
        end
    end

    assign db_estado = LARGURA_ESTADO'(estado);

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_drone.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_unidade_controle_drone: directed self-checking bench for the FSM.    |
// |                                                Revision: 1.0            |
// +-------------------------------------------------------------------------+
module tb_unidade_controle_drone;
    import drone_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar, confirma, colisao, fim_espera, fim_mapa;
    logic       zeraPosicoes, resetaVidas, zeraT, contaT, move_drone;
    logic       desloca_horizontal, escolhe_modo, escolhe_vida;
    logic       pronto, ganhou, perdeu;
    logic [3:0] db_estado;

    int compared   = 0;
    int mismatched = 0;

    // Output vector order: zP rV zT cT mv dh em ev pr g p
    localparam logic [10:0] O_INICIAL = 11'b00000000000;
    localparam logic [10:0] O_PREPARA = 11'b11100000000;
    localparam logic [10:0] O_MODO    = 11'b00000010000;
    localparam logic [10:0] O_VIDA    = 11'b00000001000;
    localparam logic [10:0] O_INICIA  = 11'b10100000000;
    localparam logic [10:0] O_ESPERA  = 11'b00011000000;
    localparam logic [10:0] O_COMPARA = 11'b00000000000;
    localparam logic [10:0] O_DESLOCA = 11'b00100100000;
    localparam logic [10:0] O_GANHOU  = 11'b00000000110;
    localparam logic [10:0] O_PERDEU  = 11'b00000000101;

    unidade_controle_drone #(.LARGURA_ESTADO(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .iniciar            (iniciar),
        .confirma           (confirma),
        .colisao            (colisao),
        .fim_espera         (fim_espera),
        .fim_mapa           (fim_mapa),
        .zeraPosicoes       (zeraPosicoes),
        .resetaVidas        (resetaVidas),
        .zeraT              (zeraT),
        .contaT             (contaT),
        .move_drone         (move_drone),
        .desloca_horizontal (desloca_horizontal),
        .escolhe_modo       (escolhe_modo),
        .escolhe_vida       (escolhe_vida),
        .pronto             (pronto),
        .ganhou             (ganhou),
        .perdeu             (perdeu),
        .db_estado          (db_estado)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] exp_st, input logic [10:0] exp_out);
        logic [10:0] obs_out;
        obs_out = {zeraPosicoes, resetaVidas, zeraT, contaT, move_drone, desloca_horizontal,
                   escolhe_modo, escolhe_vida, pronto, ganhou, perdeu};
        compared++;
        assert (db_estado === exp_st) else begin
            mismatched++;
            $error("FAIL %s state: observed %0d expected %0d", tag, db_estado, exp_st);
        end
        compared++;
        assert (obs_out === exp_out) else begin
            mismatched++;
            $error("FAIL %s outputs: observed %b expected %b", tag, obs_out, exp_out);
        end
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; confirma = 1'b0;
        colisao = 1'b0; fim_espera = 1'b0; fim_mapa = 1'b0;
        step(); step();
        check("reset", 4'd0, O_INICIAL);
        reset = 1'b0;
        step(); step();
        check("idle", 4'd0, O_INICIAL);

        // Setup
        iniciar = 1'b1; step();
        check("prepara", 4'd1, O_PREPARA);
        iniciar = 1'b0; step();
        check("modo", 4'd2, O_MODO);
        confirma = 1'b1; step();
        check("vida_press", 4'd3, O_VIDA);
        for (int i = 0; i < 4; i++) step();
        check("vida_held", 4'd3, O_VIDA);
        confirma = 1'b0; step();
        check("vida_release", 4'd3, O_VIDA);
        confirma = 1'b1; step();
        check("inicia", 4'd4, O_INICIA);
        confirma = 1'b0; step();
        check("espera", 4'd5, O_ESPERA);

        // Restart ignored mid-game
        iniciar = 1'b1; step();
        check("espera_iniciar", 4'd5, O_ESPERA);
        iniciar = 1'b0;

        // Plain play step
        fim_espera = 1'b1; step();
        check("compara", 4'd6, O_COMPARA);
        fim_espera = 1'b0; step();
        check("desloca", 4'd7, O_DESLOCA);
        step();
        check("desloca_end", 4'd5, O_ESPERA);

        // Win
        fim_espera = 1'b1; step();
        check("compara_w", 4'd6, O_COMPARA);
        fim_espera = 1'b0; fim_mapa = 1'b1; step();
        check("ganhou", 4'd8, O_GANHOU);
        fim_mapa = 1'b0; step();
        check("ganhou_hold", 4'd8, O_GANHOU);
        confirma = 1'b1; step();
        check("ganhou_conf", 4'd2, O_MODO);
        confirma = 1'b0; step();
        confirma = 1'b1; step();
        check("vida2", 4'd3, O_VIDA);
        confirma = 1'b0; step();
        confirma = 1'b1; step();
        check("inicia2", 4'd4, O_INICIA);
        confirma = 1'b0; step();
        check("espera2", 4'd5, O_ESPERA);

        // Lose with simultaneous flags
        fim_espera = 1'b1; step();
        fim_espera = 1'b0; colisao = 1'b1; fim_mapa = 1'b1; step();
        check("perdeu", 4'd9, O_PERDEU);
        colisao = 1'b0; fim_mapa = 1'b0;
        iniciar = 1'b1; step();
        check("perdeu_iniciar", 4'd1, O_PREPARA);
        iniciar = 1'b0; step();
        check("modo3", 4'd2, O_MODO);

        // Asynchronous reset mid-game
        confirma = 1'b1; step();
        confirma = 1'b0;
        check("vida3", 4'd3, O_VIDA);
        reset = 1'b1; #1;
        check("async_reset", 4'd0, O_INICIAL);
        step(); reset = 1'b0; step();
        check("after_reset", 4'd0, O_INICIAL);

        // Illegal state recovery
        iniciar = 1'b1; step(); iniciar = 1'b0; step();
        force dut.estado = estado_t'(4'hC);
        #1;
        compared++;
        assert (db_estado === 4'hC) else begin
            mismatched++;
            $error("FAIL force_illegal: observed %0d expected 12", db_estado);
        end
        step();
        release dut.estado;
        step();
        check("illegal_recover", 4'd0, O_INICIAL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
